// File: rtl/bcd_countdown_timer_pkg.sv
// bcd_countdown_timer_pkg: state encoding, BCD constants and the digit sanitizer shared by the timer
package bcd_countdown_timer_pkg;
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] PAUSE    = 2'd2;
   localparam logic [1:0] FINISHED = 2'd3;
   localparam logic [3:0] TENS_MAX  = 4'h5;
   localparam logic [3:0] ONES_MAX  = 4'h9;
   localparam logic [7:0] ZERO_BCD  = 8'h00;
   localparam logic [7:0] MAX60_BCD = 8'h59;
   // Clamp each digit to its legal maximum so loaded values are always valid 00-59 BCD
   function automatic logic [7:0] sanitize(input logic [7:0] d);
      return {(d[7:4] > TENS_MAX) ? TENS_MAX : d[7:4], (d[3:0] > ONES_MAX) ? ONES_MAX : d[3:0]};
   endfunction
endpackage

// File: rtl/bcd_countdown_timer_down60.sv
// bcd_down60: one 00-59 BCD down-counter field with sanitized load and borrow-out
module bcd_down60
   import bcd_countdown_timer_pkg::*;
(
   input  logic       CP,
   input  logic       CR,
   input  logic       EN,
   input  logic       LD,
   input  logic [7:0] D,
   output logic [7:0] Q,
   output logic       BO
);
   logic [7:0] r_q;
   logic [7:0] w_dec;
   assign w_dec = (r_q[3:0] != 4'h0) ? {r_q[7:4], r_q[3:0] - 4'h1} :
                  (r_q[7:4] != 4'h0) ? {r_q[7:4] - 4'h1, ONES_MAX} : MAX60_BCD;
   assign Q  = r_q;
   assign BO = EN & (r_q == ZERO_BCD);
   // Load wins over decrement; a borrow-in at 00 wraps to 59 and raises BO
   always_ff @(posedge CP or posedge CR)
      if (CR) r_q <= ZERO_BCD;
      else if (LD) r_q <= sanitize(D);
      else if (EN) r_q <= w_dec;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: loadable mm:ss BCD countdown with run/pause control and expiry flags
module bcd_countdown_timer
   import bcd_countdown_timer_pkg::*;
(
   input  logic       CP,
   input  logic       CR,
   input  logic       TICK,
   input  logic       LOAD,
   input  logic [7:0] LD_MIN,
   input  logic [7:0] LD_SEC,
   input  logic       START,
   input  logic       STOP,
   output logic [7:0] MIN,
   output logic [7:0] SEC,
   output logic       RUNNING,
   output logic       DONE,
   output logic       EXPIRED
);
   logic [1:0] r_state;
   logic       r_running, r_done, r_expired;
   logic [1:0] w_next;
   logic       w_tick, w_sec_bo, w_min_bo, w_expire, w_start_ok;
   assign w_tick     = TICK & (r_state == RUN) & ~LOAD & ~STOP;
   // A borrow out of the minutes field would mean passing 00:00; treat it as expiry too
   assign w_expire   = w_tick & (({MIN, SEC} == {ZERO_BCD, 8'h01}) | w_min_bo);
   assign w_start_ok = START & ((r_state == IDLE) | (r_state == PAUSE)) & ({MIN, SEC} != {ZERO_BCD, ZERO_BCD});
   assign w_next     = LOAD ? IDLE :
                       STOP ? ((r_state == RUN) ? PAUSE : r_state) :
                       w_start_ok ? RUN :
                       w_expire ? FINISHED : r_state;
   assign RUNNING = r_running;
   assign DONE    = r_done;
   assign EXPIRED = r_expired;
   bcd_down60 u_sec (
      .CP(CP), .CR(CR), .EN(w_tick), .LD(LOAD), .D(LD_SEC), .Q(SEC), .BO(w_sec_bo)
   );
   bcd_down60 u_min (
      .CP(CP), .CR(CR), .EN(w_sec_bo), .LD(LOAD), .D(LD_MIN), .Q(MIN), .BO(w_min_bo)
   );
   // Control state plus registered RUNNING, one-cycle DONE and sticky EXPIRED
   always_ff @(posedge CP or posedge CR)
      if (CR) begin
         r_state   <= IDLE;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_running <= (w_next == RUN);
         r_done    <= w_expire;
         r_expired <= LOAD ? 1'b0 : (r_expired | w_expire);
      end
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed and randomized checks against a seconds-based reference model
module tb_bcd_countdown_timer;
   logic       CP = 1'b0, CR = 1'b0, TICK = 1'b0, LOAD = 1'b0, START = 1'b0, STOP = 1'b0;
   logic [7:0] LD_MIN = 8'h00, LD_SEC = 8'h00;
   logic [7:0] MIN, SEC;
   logic       RUNNING, DONE, EXPIRED;
   int n_checks = 0, n_pass = 0;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FIN = 3;
   int m_secs = 0, m_st = M_IDLE;
   bit m_done = 1'b0, m_exp = 1'b0;

   always #5 CP = ~CP;

   bcd_countdown_timer dut (
      .CP(CP), .CR(CR), .TICK(TICK), .LOAD(LOAD), .LD_MIN(LD_MIN), .LD_SEC(LD_SEC),
      .START(START), .STOP(STOP), .MIN(MIN), .SEC(SEC), .RUNNING(RUNNING),
      .DONE(DONE), .EXPIRED(EXPIRED)
   );

   function automatic int san(input logic [7:0] d);
      int t, o;
      t = int'(d[7:4]);
      o = int'(d[3:0]);
      return (t > 5 ? 5 : t) * 10 + (o > 9 ? 9 : o);
   endfunction

   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   function automatic logic [18:0] exp_vec();
      return {bcd(m_secs / 60), bcd(m_secs % 60), m_st == M_RUN, m_done, m_exp};
   endfunction

   function automatic logic [18:0] act_vec();
      return {MIN, SEC, RUNNING, DONE, EXPIRED};
   endfunction

   task automatic model_reset();
      m_secs = 0; m_st = M_IDLE; m_done = 1'b0; m_exp = 1'b0;
   endtask

   task automatic cyc(input logic ld, input logic stp, input logic sta, input logic tk,
                      input logic [7:0] lm = 8'h00, input logic [7:0] ls = 8'h00);
      @(negedge CP);
      LOAD = ld; STOP = stp; START = sta; TICK = tk; LD_MIN = lm; LD_SEC = ls;
      m_done = 1'b0;
      if (ld) begin
         m_secs = san(lm) * 60 + san(ls); m_st = M_IDLE; m_exp = 1'b0;
      end else if (stp) begin
         if (m_st == M_RUN) m_st = M_PAUSE;
      end else if (sta && (m_st == M_IDLE || m_st == M_PAUSE) && m_secs != 0) begin
         m_st = M_RUN;
      end else if (tk && m_st == M_RUN) begin
         m_secs = m_secs - 1;
         if (m_secs == 0) begin m_st = M_FIN; m_done = 1'b1; m_exp = 1'b1; end
      end
      @(posedge CP);
      #1;
      LOAD = 1'b0; STOP = 1'b0; START = 1'b0; TICK = 1'b0;
   endtask

   task automatic test_reset();
      CR = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (act_vec() !== 19'h0) $display("FAIL reset_initial got %h want %h", act_vec(), 19'h0);
      else n_pass++;
      @(negedge CP) CR = 1'b0;
      cyc(1, 0, 0, 0, 8'h12, 8'h34);
      cyc(0, 0, 1, 0);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h12, 8'h34, 1'b1}) $display("FAIL reset_prerun got %h want %h", {MIN, SEC, RUNNING}, {8'h12, 8'h34, 1'b1});
      else n_pass++;
      #2 CR = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (act_vec() !== 19'h0) $display("FAIL reset_async got %h want %h", act_vec(), 19'h0);
      else n_pass++;
      @(negedge CP) CR = 1'b0;
      cyc(0, 0, 0, 1);
      n_checks++;
      if (act_vec() !== exp_vec() || {MIN, SEC} !== 16'h0000) $display("FAIL reset_tick got %h want %h", act_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_countdown();
      cyc(1, 0, 0, 0, 8'h10, 8'h00);
      cyc(0, 0, 1, 0);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h10, 8'h00, 1'b1}) $display("FAIL countdown_start got %h want %h", {MIN, SEC, RUNNING}, {8'h10, 8'h00, 1'b1});
      else n_pass++;
      cyc(0, 0, 0, 1);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h09, 8'h59, 1'b1}) $display("FAIL countdown_borrow got %h want %h", {MIN, SEC, RUNNING}, {8'h09, 8'h59, 1'b1});
      else n_pass++;
      cyc(0, 0, 0, 1);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h09, 8'h58, 1'b1}) $display("FAIL countdown_step got %h want %h", {MIN, SEC, RUNNING}, {8'h09, 8'h58, 1'b1});
      else n_pass++;
   endtask

   task automatic test_expiry();
      cyc(1, 0, 0, 0, 8'h00, 8'h01);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      n_checks++;
      if (act_vec() !== {8'h00, 8'h00, 3'b011}) $display("FAIL expiry_edge got %h want %h", act_vec(), {8'h00, 8'h00, 3'b011});
      else n_pass++;
      cyc(0, 0, 0, 1);
      n_checks++;
      if (act_vec() !== {8'h00, 8'h00, 3'b001}) $display("FAIL expiry_done_pulse got %h want %h", act_vec(), {8'h00, 8'h00, 3'b001});
      else n_pass++;
      cyc(0, 0, 1, 0);
      n_checks++;
      if (act_vec() !== {8'h00, 8'h00, 3'b001}) $display("FAIL expiry_start_ignored got %h want %h", act_vec(), {8'h00, 8'h00, 3'b001});
      else n_pass++;
      cyc(1, 0, 0, 0, 8'h00, 8'h05);
      n_checks++;
      if (act_vec() !== {8'h00, 8'h05, 3'b000}) $display("FAIL expiry_reload got %h want %h", act_vec(), {8'h00, 8'h05, 3'b000});
      else n_pass++;
   endtask

   task automatic test_sanitize();
      cyc(1, 0, 0, 0, 8'hFF, 8'h7A);
      n_checks++;
      if ({MIN, SEC} !== 16'h5959) $display("FAIL sanitize_ff_7a got %h want %h", {MIN, SEC}, 16'h5959);
      else n_pass++;
      cyc(1, 0, 0, 0, 8'h3C, 8'hA0);
      n_checks++;
      if ({MIN, SEC} !== 16'h3950) $display("FAIL sanitize_3c_a0 got %h want %h", {MIN, SEC}, 16'h3950);
      else n_pass++;
      cyc(1, 0, 0, 0, 8'h00, 8'h00);
      cyc(0, 0, 1, 0);
      n_checks++;
      if (act_vec() !== 19'h0) $display("FAIL start_at_zero got %h want %h", act_vec(), 19'h0);
      else n_pass++;
   endtask

   task automatic test_pause();
      cyc(1, 0, 0, 0, 8'h00, 8'h30);
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 1);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h00, 8'h30, 1'b0}) $display("FAIL pause_stop_tick got %h want %h", {MIN, SEC, RUNNING}, {8'h00, 8'h30, 1'b0});
      else n_pass++;
      cyc(0, 0, 0, 1);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h00, 8'h30, 1'b0}) $display("FAIL pause_tick got %h want %h", {MIN, SEC, RUNNING}, {8'h00, 8'h30, 1'b0});
      else n_pass++;
      cyc(0, 1, 1, 0);
      n_checks++;
      if (RUNNING !== 1'b0) $display("FAIL pause_stop_start got %b want %b", RUNNING, 1'b0);
      else n_pass++;
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h00, 8'h29, 1'b1}) $display("FAIL pause_resume got %h want %h", {MIN, SEC, RUNNING}, {8'h00, 8'h29, 1'b1});
      else n_pass++;
   endtask

   task automatic test_load_priority();
      cyc(1, 0, 0, 0, 8'h01, 8'h00);
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 1, 8'h02, 8'h00);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h02, 8'h00, 1'b0}) $display("FAIL load_over_tick got %h want %h", {MIN, SEC, RUNNING}, {8'h02, 8'h00, 1'b0});
      else n_pass++;
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 1);
      n_checks++;
      if ({MIN, SEC, RUNNING} !== {8'h02, 8'h00, 1'b0}) $display("FAIL idle_stop_start got %h want %h", {MIN, SEC, RUNNING}, {8'h02, 8'h00, 1'b0});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      cyc(1, 0, 0, 0, 8'h01, 8'h02);
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 0, 1);
         n_checks++;
         if (act_vec() !== exp_vec()) $display("FAIL b2b_tick%0d got %h want %h", i, act_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({MIN, SEC} !== 16'h0056) $display("FAIL b2b_final got %h want %h", {MIN, SEC}, 16'h0056);
      else n_pass++;
   endtask

   task automatic test_random();
      logic ld, stp, sta, tk;
      logic [7:0] lm, ls;
      for (int i = 0; i < 400; i++) begin
         ld  = ($urandom_range(0, 19) == 0);
         stp = ($urandom_range(0, 19) == 0);
         sta = ($urandom_range(0, 6) == 0);
         tk  = ($urandom_range(0, 9) < 6);
         lm  = ($urandom_range(0, 2) != 0) ? 8'h00 : 8'($urandom);
         ls  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
         cyc(ld, stp, sta, tk, lm, ls);
         n_checks++;
         if (act_vec() !== exp_vec()) $display("FAIL random_cycle%0d got %h want %h", i, act_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_expiry();
      test_sanitize();
      test_pause();
      test_load_priority();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
